// File: rtl/bf_io_pkg.sv
// bf_io_pkg: shared encodings and sizing helpers for the byte I/O serial blocks
package bf_io_pkg;
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;
  localparam int CLK_DIV_DEFAULT = 434;
  localparam int BAUD_W_DEFAULT = $clog2(CLK_DIV_DEFAULT);
  function automatic int baud_width(input int div);
    return $clog2(div);
  endfunction
endpackage

// File: rtl/bf_byte_fifo.sv
// bf_byte_fifo: synchronous byte FIFO with first-word-fall-through output
module bf_byte_fifo #(
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  push,
  input  logic                  pop,
  input  logic [7:0]            din,
  output logic [7:0]            dout,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  logic [7:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wptr, rptr;
  logic wr, rd;
  always_comb begin
    full = count == (ADDR_WIDTH+1)'(DEPTH);
    empty = count == '0;
    wr = push && !full;
    rd = pop && !empty;
    dout = mem[rptr];
  end
  always_ff @(posedge clk)
    if (rst_i) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      wptr <= wptr + ADDR_WIDTH'(wr);
      rptr <= rptr + ADDR_WIDTH'(rd);
      count <= count + (ADDR_WIDTH+1)'(wr) - (ADDR_WIDTH+1)'(rd);
    end
  always_ff @(posedge clk)
    if (wr) mem[wptr] <= din;
endmodule

// File: rtl/bf_uart_tx.sv
// bf_uart_tx: FIFO-buffered 8N1 serial transmitter for the processor byte output channel
module bf_uart_tx
  import bf_io_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT,
  parameter int FIFO_ADDR_WIDTH = 2
) (
  input  logic       clk,
  input  logic       rst_i,
  input  logic [7:0] data,
  input  logic       write,
  output logic       busy,
  output logic       txd,
  output logic       idle
);
  localparam int BW = baud_width(CLK_DIV);
  logic [1:0] state;
  logic [BW-1:0] baud_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shreg, dout;
  logic [FIFO_ADDR_WIDTH:0] count;
  logic empty, pop, baud_end;
  bf_byte_fifo #(.ADDR_WIDTH(FIFO_ADDR_WIDTH)) u_fifo (
    .clk(clk),
    .rst_i(rst_i),
    .push(write),
    .pop(pop),
    .din(data),
    .dout(dout),
    .count(count),
    .full(busy),
    .empty(empty)
  );
  always_comb begin
    baud_end = baud_cnt == BW'(CLK_DIV - 1);
    pop = !empty && (state == IDLE || (state == STOP && baud_end));
    idle = count == '0 && state == IDLE;
  end
  // txd follows the current state one cycle late, so every bit still lasts CLK_DIV cycles
  always_ff @(posedge clk)
    if (rst_i) begin
      state <= IDLE;
      baud_cnt <= '0;
      bit_cnt <= '0;
      shreg <= '0;
      txd <= 1'b1;
    end else begin
      txd <= state == START ? 1'b0 : state == DATA ? shreg[0] : 1'b1;
      baud_cnt <= (pop || baud_end || state == IDLE) ? '0 : baud_cnt + BW'(1);
      bit_cnt <= state == START ? 3'd0 : (state == DATA && baud_end) ? bit_cnt + 3'd1 : bit_cnt;
      shreg <= pop ? dout : (state == DATA && baud_end) ? shreg >> 1 : shreg;
      state <= pop ? START : !baud_end ? state : state == START ? DATA :
               state == DATA ? (bit_cnt == 3'd7 ? STOP : DATA) : IDLE;
    end
endmodule
